// File: rtl/list_lookup_pkg.sv
// Shared types and the mask/match compare for the table-driven decode stage.
// Widths here are the stage's build widths; the top-level parameters default to them.
package list_lookup_pkg;

    localparam int LL_INST_W      = 32;
    localparam int LL_NUM_ENTRIES = 4;
    localparam int LL_SIG_W       = 3;
    localparam int LL_IDX_W       = $clog2(LL_NUM_ENTRIES);

    typedef struct packed {
        logic                 en;
        logic [LL_INST_W-1:0] mask;
        logic [LL_INST_W-1:0] match;
        logic [LL_SIG_W-1:0]  sigs;
    } decode_entry_t;

    typedef struct packed {
        logic [LL_SIG_W-1:0] sigs;
        logic                hit;
        logic [LL_IDX_W-1:0] idx;
    } decode_result_t;

    function automatic logic lldec_match(
        input decode_entry_t        entry,
        input logic [LL_INST_W-1:0] inst
    );
        return entry.en && ((inst & entry.mask) == (entry.match & entry.mask));
    endfunction

endpackage

// File: rtl/lldec_prio_match.sv
// Combinational table compare plus lowest-index-wins priority encoder.
// LLDEC_MULTIHIT_CHK_EN adds a flag for two or more simultaneous matches.
module lldec_prio_match
    import list_lookup_pkg::*;
#(
    parameter int                  NUM_ENTRIES  = LL_NUM_ENTRIES,
    parameter logic [LL_SIG_W-1:0] DEFAULT_SIGS = '0
) (
    input  decode_entry_t [NUM_ENTRIES-1:0] tbl,
    input  logic [LL_INST_W-1:0]            inst,
`ifdef LLDEC_MULTIHIT_CHK_EN
    output logic                            multihit,
`endif
    output decode_result_t                  result
);

    // Scan high to low so the lowest matching entry is the last to land.
    always_comb begin
        result = '{sigs: DEFAULT_SIGS, hit: 1'b0, idx: '0};
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (lldec_match(tbl[i], inst)) begin
                result.sigs = tbl[i].sigs;
                result.hit  = 1'b1;
                result.idx  = LL_IDX_W'(i);
            end
        end
    end

`ifdef LLDEC_MULTIHIT_CHK_EN
    logic seen;

    always_comb begin
        seen     = 1'b0;
        multihit = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (lldec_match(tbl[i], inst)) begin
                if (seen) multihit = 1'b1;
                seen = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/list_lookup_decode_stage.sv
// Registered table-driven decode stage with valid/ready on both sides.
// Optional LLDEC_MULTIHIT_CHK_EN adds out_multihit and err_multihit_sticky.
module list_lookup_decode_stage
    import list_lookup_pkg::*;
#(
    parameter int               INST_W       = LL_INST_W,
    parameter int               NUM_ENTRIES  = LL_NUM_ENTRIES,
    parameter int               SIG_W        = LL_SIG_W,
    parameter logic [SIG_W-1:0] DEFAULT_SIGS = '0,
    localparam int              IDX_W        = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIG_W-1:0]  out_sigs,
    output logic              out_hit,
    output logic [IDX_W-1:0]  out_idx,
`ifdef LLDEC_MULTIHIT_CHK_EN
    output logic              out_multihit,
    output logic              err_multihit_sticky,
`endif
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic [INST_W-1:0] cfg_mask,
    input  logic [INST_W-1:0] cfg_match,
    input  logic [SIG_W-1:0]  cfg_sigs
);

    decode_entry_t [NUM_ENTRIES-1:0] tbl;
    decode_result_t                  dec;
    decode_result_t                  res_q;
    logic                            accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign out_sigs = res_q.sigs;
    assign out_hit  = res_q.hit;
    assign out_idx  = res_q.idx;

`ifdef LLDEC_MULTIHIT_CHK_EN
    logic dec_multihit;

    lldec_prio_match #(
        .NUM_ENTRIES  (NUM_ENTRIES),
        .DEFAULT_SIGS (DEFAULT_SIGS)
    ) u_match (
        .tbl      (tbl),
        .inst     (in_inst),
        .multihit (dec_multihit),
        .result   (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_multihit        <= 1'b0;
            err_multihit_sticky <= 1'b0;
        end else if (accept) begin
            out_multihit <= dec_multihit;
            if (dec_multihit) err_multihit_sticky <= 1'b1;
        end
    end
`else
    lldec_prio_match #(
        .NUM_ENTRIES  (NUM_ENTRIES),
        .DEFAULT_SIGS (DEFAULT_SIGS)
    ) u_match (
        .tbl    (tbl),
        .inst   (in_inst),
        .result (dec)
    );
`endif

    // Decode reads the table before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            tbl       <= '0;
            out_valid <= 1'b0;
            res_q     <= '{sigs: DEFAULT_SIGS, hit: 1'b0, idx: '0};
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cfg_we && cfg_idx == IDX_W'(i)) begin
                    tbl[i] <= '{en: cfg_en, mask: cfg_mask,
                                match: cfg_match, sigs: cfg_sigs};
                end
            end
            if (accept) begin
                out_valid <= 1'b1;
                res_q     <= dec;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_list_lookup_decode_stage.sv
// Self-checking bench: behavioural model, per-cycle compare, directed vectors.
// Build with LLDEC_MULTIHIT_CHK_EN defined to cover the multihit ports.
module tb_list_lookup_decode_stage;

    localparam int NE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_sigs;
    logic        out_hit;
    logic [1:0]  out_idx;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en;
    logic [31:0] cfg_mask;
    logic [31:0] cfg_match;
    logic [2:0]  cfg_sigs;
`ifdef LLDEC_MULTIHIT_CHK_EN
    logic        out_multihit;
    logic        err_multihit_sticky;
`endif

    int tests  = 0;
    int failed = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    list_lookup_decode_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_inst             (in_inst),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_sigs            (out_sigs),
        .out_hit             (out_hit),
        .out_idx             (out_idx),
`ifdef LLDEC_MULTIHIT_CHK_EN
        .out_multihit        (out_multihit),
        .err_multihit_sticky (err_multihit_sticky),
`endif
        .cfg_we              (cfg_we),
        .cfg_idx             (cfg_idx),
        .cfg_en              (cfg_en),
        .cfg_mask            (cfg_mask),
        .cfg_match           (cfg_match),
        .cfg_sigs            (cfg_sigs)
    );

    // Model state
    bit          m_en    [NE];
    logic [31:0] m_mask  [NE];
    logic [31:0] m_match [NE];
    logic [2:0]  m_sigs  [NE];
    bit          e_valid;
    logic [2:0]  e_sigs;
    bit          e_hit;
    int          e_idx;
    bit          e_multi;
    bit          e_sticky;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NE; i++) begin
                m_en[i] = 0; m_mask[i] = 0; m_match[i] = 0; m_sigs[i] = 0;
            end
            e_valid = 0; e_sigs = 0; e_hit = 0; e_idx = 0;
            e_multi = 0; e_sticky = 0;
        end else begin
            if (in_valid && (!e_valid || out_ready)) begin
                int n;
                n = 0;
                e_sigs = 3'h0; e_hit = 0; e_idx = 0;
                for (int i = 0; i < NE; i++) begin
                    if (m_en[i] && ((in_inst & m_mask[i]) ==
                                    (m_match[i] & m_mask[i]))) begin
                        if (n == 0) begin
                            e_sigs = m_sigs[i]; e_hit = 1; e_idx = i;
                        end
                        n++;
                    end
                end
                e_valid = 1;
                e_multi = (n >= 2);
                if (n >= 2) e_sticky = 1;
            end else if (out_ready) begin
                e_valid = 0;
            end
            if (cfg_we) begin
                m_en[cfg_idx]    = cfg_en;
                m_mask[cfg_idx]  = cfg_mask;
                m_match[cfg_idx] = cfg_match;
                m_sigs[cfg_idx]  = cfg_sigs;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (started && !reset) begin
            chk("model_valid", 32'(out_valid), 32'(e_valid));
            chk("model_sigs", 32'(out_sigs), 32'(e_sigs));
            chk("model_hit", 32'(out_hit), 32'(e_hit));
            chk("model_idx", 32'(out_idx), 32'(e_idx));
            chk("model_ready", 32'(in_ready), 32'(!e_valid || out_ready));
`ifdef LLDEC_MULTIHIT_CHK_EN
            if (e_valid) chk("model_multi", 32'(out_multihit), 32'(e_multi));
            chk("model_sticky", 32'(err_multihit_sticky), 32'(e_sticky));
`endif
        end
    end

    task automatic write_entry(input int idx, input bit en, input logic [31:0] mask,
                               input logic [31:0] match, input logic [2:0] sigs);
        cfg_we = 1; cfg_idx = 2'(idx); cfg_en = en;
        cfg_mask = mask; cfg_match = match; cfg_sigs = sigs;
        @(negedge clk);
        cfg_we = 0;
    endtask

    initial begin
        reset = 1; in_valid = 0; in_inst = 0; out_ready = 1;
        cfg_we = 0; cfg_idx = 0; cfg_en = 0;
        cfg_mask = 0; cfg_match = 0; cfg_sigs = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        started = 1;
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_sigs", 32'(out_sigs), 0);
        chk("reset_idx", 32'(out_idx), 0);

        // Empty table -> miss
        in_valid = 1; in_inst = 32'h257B;
        @(negedge clk);
        chk("miss_valid", 32'(out_valid), 1);
        chk("miss_sigs", 32'(out_sigs), 0);
        chk("miss_hit", 32'(out_hit), 0);
        in_valid = 0;
        @(negedge clk);

        write_entry(0, 1, 32'hFFFF_FFFF, 32'h277B, 3'd4);
        write_entry(1, 1, 32'hFFFF_FFFF, 32'h257B, 3'd1);

        // Back-to-back
        in_valid = 1; in_inst = 32'h277B;
        @(negedge clk);
        chk("b2b0_sigs", 32'(out_sigs), 4);
        chk("b2b0_idx", 32'(out_idx), 0);
        in_inst = 32'h257B;
        @(negedge clk);
        chk("b2b1_valid", 32'(out_valid), 1);
        chk("b2b1_sigs", 32'(out_sigs), 1);
        chk("b2b1_idx", 32'(out_idx), 1);
        in_valid = 0;
        @(negedge clk);

        // Priority with overlapping entries
        write_entry(0, 1, 32'h0000_007F, 32'h7B, 3'd2);
        in_valid = 1; in_inst = 32'h257B;
        @(negedge clk);
        chk("prio_sigs", 32'(out_sigs), 2);
        chk("prio_idx", 32'(out_idx), 0);
`ifdef LLDEC_MULTIHIT_CHK_EN
        chk("prio_multihit", 32'(out_multihit), 1);
        chk("prio_sticky", 32'(err_multihit_sticky), 1);
`endif
        in_valid = 0;
        @(negedge clk);
        write_entry(0, 1, 32'hFFFF_FFFF, 32'h277B, 3'd4);
        @(negedge clk);

        // Backpressure
        out_ready = 0; in_valid = 1; in_inst = 32'h277B;
        @(negedge clk);
        in_inst = 32'h257B;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_sigs", 32'(out_sigs), 4);
            chk("stall_ready", 32'(in_ready), 0);
        end
        out_ready = 1;
        @(negedge clk);
        chk("release_sigs", 32'(out_sigs), 1);
        chk("release_idx", 32'(out_idx), 1);
        in_valid = 0;
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_hold", 32'(out_sigs), 1);

        // Write coinciding with accept
        in_valid = 1; in_inst = 32'h257B;
        cfg_we = 1; cfg_idx = 1; cfg_en = 1;
        cfg_mask = 32'hFFFF_FFFF; cfg_match = 32'h257B; cfg_sigs = 3'd6;
        @(negedge clk);
        cfg_we = 0;
        chk("wr_old_sigs", 32'(out_sigs), 1);
        @(negedge clk);
        chk("wr_new_sigs", 32'(out_sigs), 6);
        in_valid = 0;
        @(negedge clk);

        // Reset while holding a result
        out_ready = 0; in_valid = 1; in_inst = 32'h277B;
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 1);
        in_valid = 0; reset = 1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sigs", 32'(out_sigs), 0);
        reset = 0; out_ready = 1; in_valid = 1; in_inst = 32'h277B;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_hit", 32'(out_hit), 0);
        chk("post_rst_sigs", 32'(out_sigs), 0);
`ifdef LLDEC_MULTIHIT_CHK_EN
        chk("post_rst_sticky", 32'(err_multihit_sticky), 0);
`endif
        in_valid = 0;
        repeat (2) @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
